mem_arbiter: RTL and testbench

- Shares the single unified memory between two requesters: requester 0 is the CPU fetch/execute path, and requester 1 is the program loader/debug port.
- Serialises accesses through a small FSM and drives the memory's rd/wrt strobes, address and write data.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the address/data muxing and the memory instance at CPU top level.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, status and memory-side signals shared by the arbiter and its environment.
// The arbiter connects through the slave modport; the CPU/loader/memory side uses master.
interface mem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_lock;
  logic          r0_ack;

  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_lock;
  logic          r1_ack;

  logic [DW-1:0] rdata;
  logic [1:0]    gnt;
  logic          busy;

  logic          mem_rd;
  logic          mem_wrt;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
    input  mem_rdata,
    output r0_ack, r1_ack, rdata, gnt, busy,
    output mem_rd, mem_wrt, mem_addr, mem_wdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
    output mem_rdata,
    input  r0_ack, r1_ack, rdata, gnt, busy,
    input  mem_rd, mem_wrt, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the unified memory: IDLE -> ACCESS -> RESP per transaction.
// Optional bus-lock ownership is compiled in when MEM_ARB_LOCK_EN is defined.
module mem_arbiter #(
  parameter int AW        = 5,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          winner_q, winner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          rd_q, rd_d;
  logic          wrt_q, wrt_d;

  logic          anyReq;
  logic          pick;

`ifdef MEM_ARB_LOCK_EN
  logic          lockValid_q, lockValid_d;
  logic          lockOwner_q, lockOwner_d;
  logic          ownerReq;

  assign ownerReq = lockOwner_q ? bus.r1_req : bus.r0_req;
`else
  logic          unusedLocks;

  assign unusedLocks = bus.r0_lock ^ bus.r1_lock;
`endif

  // Winner selection; a live lock overrides both round-robin and fixed priority.
  always_comb begin
    anyReq = bus.r0_req | bus.r1_req;
    if (bus.r0_req && bus.r1_req) begin
      pick = (PRIO_MODE == 1) ? 1'b0 : ~last_q;
    end else begin
      pick = bus.r1_req;
    end
`ifdef MEM_ARB_LOCK_EN
    if (lockValid_q && ownerReq) begin
      pick = lockOwner_q;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    gnt_d    = gnt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rd_d     = rd_q;
    wrt_d    = wrt_q;
`ifdef MEM_ARB_LOCK_EN
    lockValid_d = lockValid_q;
    lockOwner_d = lockOwner_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_LOCK_EN
        if (lockValid_q && !ownerReq) begin
          lockValid_d = 1'b0;
        end
`endif
        if (anyReq) begin
          winner_d = pick;
          we_d     = pick ? bus.r1_we    : bus.r0_we;
          addr_d   = pick ? bus.r1_addr  : bus.r0_addr;
          wdata_d  = pick ? bus.r1_wdata : bus.r0_wdata;
          gnt_d    = pick ? 2'b10 : 2'b01;
          cnt_d    = we_d ? 2'd0 : LAT_M1;
          rd_d     = ~we_d;
          wrt_d    = we_d;
          state_d  = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q == 2'd0) begin
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
          rd_d    = 1'b0;
          wrt_d   = 1'b0;
          ack0_d  = ~winner_q;
          ack1_d  = winner_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      RESP: begin
        last_d  = winner_q;
        gnt_d   = 2'b00;
        state_d = IDLE;
`ifdef MEM_ARB_LOCK_EN
        lockValid_d = winner_q ? bus.r1_lock : bus.r0_lock;
        lockOwner_d = winner_q;
`endif
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        rd_d    = 1'b0;
        wrt_d   = 1'b0;
      end
    endcase
  end

  // Reset drops any in-flight transaction outright: no ack, strobes low, latch discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_q    <= 2'b00;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rd_q     <= 1'b0;
      wrt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rd_q     <= rd_d;
      wrt_q    <= wrt_d;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lockValid_q <= 1'b0;
      lockOwner_q <= 1'b0;
    end else begin
      lockValid_q <= lockValid_d;
      lockOwner_q <= lockOwner_d;
    end
  end
`endif

  assign bus.r0_ack    = ack0_q;
  assign bus.r1_ack    = ack1_q;
  assign bus.rdata     = rdata_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wrt   = wrt_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: two arbiters (RD_LAT=1 round-robin, RD_LAT=3 fixed priority) share one
// stimulus stream and are compared every cycle against a transaction-countdown reference model.
module tb_mem_arbiter;

  localparam int AW     = 5;
  localparam int DW     = 8;
  localparam int NI     = 2;
  localparam int LAT_A  = 1;
  localparam int PRIO_A = 0;
  localparam int LAT_B  = 3;
  localparam int PRIO_B = 1;

  typedef struct packed {
    logic          busy;
    logic [1:0]    gnt;
    logic          ack0;
    logic          ack1;
    logic          rd;
    logic          wrt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          r0Req, r0We, r0Lock, r1Req, r1We, r1Lock;
  logic [AW-1:0] r0Addr, r1Addr;
  logic [DW-1:0] r0Wdata, r1Wdata;

  int checkCount = 0;
  int failCount  = 0;
  bit checkEn    = 1'b0;

  logic [DW-1:0] memArr [NI][32];
  logic [DW-1:0] shadow [NI][32];
  int            rdCnt  [NI];

  int            left   [NI];
  bit            owner  [NI];
  bit            mWe    [NI];
  logic [AW-1:0] mAddr  [NI];
  logic [DW-1:0] mWdata [NI];
  logic [DW-1:0] rdExp  [NI];
  bit            last   [NI];
`ifdef MEM_ARB_LOCK_EN
  bit            lockV  [NI];
  bit            lockO  [NI];
`endif

  obs_t obs [NI];

  mem_arbiter_if #(.AW(AW), .DW(DW)) busA ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) busB ();

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT_A), .PRIO_MODE(PRIO_A)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT_B), .PRIO_MODE(PRIO_B)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  always #5 clk = ~clk;

  assign busA.r0_req = r0Req;   assign busB.r0_req = r0Req;
  assign busA.r0_we = r0We;     assign busB.r0_we = r0We;
  assign busA.r0_addr = r0Addr; assign busB.r0_addr = r0Addr;
  assign busA.r0_wdata = r0Wdata; assign busB.r0_wdata = r0Wdata;
  assign busA.r0_lock = r0Lock; assign busB.r0_lock = r0Lock;
  assign busA.r1_req = r1Req;   assign busB.r1_req = r1Req;
  assign busA.r1_we = r1We;     assign busB.r1_we = r1We;
  assign busA.r1_addr = r1Addr; assign busB.r1_addr = r1Addr;
  assign busA.r1_wdata = r1Wdata; assign busB.r1_wdata = r1Wdata;
  assign busA.r1_lock = r1Lock; assign busB.r1_lock = r1Lock;

  assign obs[0] = {busA.busy, busA.gnt, busA.r0_ack, busA.r1_ack, busA.mem_rd, busA.mem_wrt,
                   busA.mem_addr, busA.mem_wdata, busA.rdata};
  assign obs[1] = {busB.busy, busB.gnt, busB.r0_ack, busB.r1_ack, busB.mem_rd, busB.mem_wrt,
                   busB.mem_addr, busB.mem_wdata, busB.rdata};

  // Memory only presents real data once the read strobe has been held for the configured latency.
  assign busA.mem_rdata = (obs[0].rd && rdCnt[0] == LAT_A - 1) ? memArr[0][obs[0].addr] : 8'hEE;
  assign busB.mem_rdata = (obs[1].rd && rdCnt[1] == LAT_B - 1) ? memArr[1][obs[1].addr] : 8'hEE;

  function automatic int latOf(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int prioOf(input int k);
    return (k == 0) ? PRIO_A : PRIO_B;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic q0, input logic w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic l0,
                               input logic q1, input logic w1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d1, input logic l1);
    r0Req = q0; r0We = w0; r0Addr = a0; r0Wdata = d0; r0Lock = l0;
    r1Req = q1; r1We = w1; r1Addr = a1; r1Wdata = d1; r1Lock = l1;
  endtask

  // A granted transaction occupies (access cycles + one response cycle); left counts that down.
  task automatic modelStep(input int k);
    bit hold;
    int w;
    hold = 1'b0;
    if (left[k] == 0) begin
`ifdef MEM_ARB_LOCK_EN
      if (lockV[k]) begin
        if (lockO[k] ? r1Req : r0Req) hold = 1'b1;
        else lockV[k] = 1'b0;
      end
`endif
      if (r0Req || r1Req) begin
`ifdef MEM_ARB_LOCK_EN
        if (hold) w = lockO[k] ? 1 : 0;
        else
`endif
        if (r0Req && r1Req) w = (prioOf(k) == 1) ? 0 : 1 - int'(last[k]);
        else w = r1Req ? 1 : 0;
        owner[k]  = (w == 1);
        mWe[k]    = (w == 1) ? r1We : r0We;
        mAddr[k]  = (w == 1) ? r1Addr : r0Addr;
        mWdata[k] = (w == 1) ? r1Wdata : r0Wdata;
        left[k]   = (mWe[k] ? 1 : latOf(k)) + 1;
      end
    end else begin
      if (left[k] == 2) begin
        if (mWe[k]) shadow[k][mAddr[k]] = mWdata[k];
        else rdExp[k] = shadow[k][mAddr[k]];
      end
      if (left[k] == 1) begin
        last[k] = owner[k];
`ifdef MEM_ARB_LOCK_EN
        lockV[k] = owner[k] ? r1Lock : r0Lock;
        lockO[k] = owner[k];
`endif
      end
      left[k] = left[k] - 1;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    logic [DW-1:0] v;
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        left[k] = 0; owner[k] = 1'b0; mWe[k] = 1'b0; mAddr[k] = '0; mWdata[k] = '0;
        rdExp[k] = '0; last[k] = 1'b1;
`ifdef MEM_ARB_LOCK_EN
        lockV[k] = 1'b0; lockO[k] = 1'b0;
`endif
        rdCnt[k] <= 0;
        for (int a = 0; a < 32; a++) begin
          v = (a == 3) ? 8'hA5 : 8'($urandom);
          memArr[k][a] <= v;
          shadow[k][a] = v;
        end
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (obs[k].wrt) memArr[k][obs[k].addr] <= obs[k].wdata;
        rdCnt[k] <= obs[k].rd ? rdCnt[k] + 1 : 0;
        modelStep(k);
      end
    end
  end

  always @(negedge clk) begin
    string p;
    bit act;
    if (checkEn) begin
      for (int k = 0; k < NI; k++) begin
        p = (k == 0) ? "A" : "B";
        act = (left[k] > 0);
        checkOutput($sformatf("%s.busy", p), obs[k].busy, act);
        checkOutput($sformatf("%s.gnt", p), obs[k].gnt, act ? (owner[k] ? 2 : 1) : 0);
        checkOutput($sformatf("%s.r0_ack", p), obs[k].ack0, left[k] == 1 && !owner[k]);
        checkOutput($sformatf("%s.r1_ack", p), obs[k].ack1, left[k] == 1 && owner[k]);
        checkOutput($sformatf("%s.oneAck", p), obs[k].ack0 & obs[k].ack1, 0);
        checkOutput($sformatf("%s.mem_rd", p), obs[k].rd, left[k] > 1 && !mWe[k]);
        checkOutput($sformatf("%s.mem_wrt", p), obs[k].wrt, left[k] > 1 && mWe[k]);
        checkOutput($sformatf("%s.mem_addr", p), obs[k].addr, mAddr[k]);
        checkOutput($sformatf("%s.mem_wdata", p), obs[k].wdata, mWdata[k]);
        checkOutput($sformatf("%s.rdata", p), obs[k].rdata, rdExp[k]);
      end
    end
  end

  task automatic measureAck(input bit who, output int nA, output int nB,
                            output logic [DW-1:0] rA, output logic [DW-1:0] rB);
    nA = 99; nB = 99; rA = '0; rB = '0;
    @(posedge clk);
    #1 applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 12 && (nA == 99 || nB == 99); n++) begin
      @(negedge clk);
      if (nA == 99 && (who ? busA.r1_ack : busA.r0_ack)) begin nA = n; rA = busA.rdata; end
      if (nB == 99 && (who ? busB.r1_ack : busB.r0_ack)) begin nB = n; rB = busB.rdata; end
    end
  endtask

  initial begin
    int nA, nB, seen;
    logic [DW-1:0] rA, rB;
    int ackA[$];
    int ackB[$];

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEn = 1'b1;
    checkOutput("A.resetGnt", busA.gnt, 0);
    checkOutput("B.resetBusy", busB.busy, 0);
    checkOutput("A.resetRdata", busA.rdata, 0);
    rst = 1'b1;

    @(negedge clk);
    applyStimulus(1, 0, 5'h03, 8'h00, 0, 0, 0, 0, 0, 0);
    measureAck(1'b0, nA, nB, rA, rB);
    checkOutput("A.readLatency", nA, LAT_A + 1);
    checkOutput("B.readLatency", nB, LAT_B + 1);
    checkOutput("A.readData", rA, 8'hA5);
    checkOutput("B.readData", rB, 8'hA5);

    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'h1F, 8'h3C, 0);
    measureAck(1'b1, nA, nB, rA, rB);
    checkOutput("A.writeLatency", nA, 2);
    checkOutput("B.writeLatency", nB, 2);
    checkOutput("A.rdataHeldOnWrite", rA, 8'hA5);

    @(negedge clk);
    applyStimulus(1, 0, 5'h04, 8'h00, 0, 1, 0, 5'h1F, 8'h00, 0);
    repeat (26) begin
      @(negedge clk);
      if (busA.r0_ack) ackA.push_back(0);
      if (busA.r1_ack) ackA.push_back(1);
      if (busB.r0_ack) ackB.push_back(0);
      if (busB.r1_ack) ackB.push_back(1);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("A.rrOrder%0d", i), (ackA.size() > i) ? ackA[i] : 9, i % 2);
      checkOutput($sformatf("B.prioOrder%0d", i), (ackB.size() > i) ? ackB[i] : 9, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 5'h1F, 8'h00, 0);
    seen = 0;
    for (int n = 0; n < 14 && seen == 0; n++) begin
      @(negedge clk);
      if (busB.r1_ack) seen = 1;
    end
    checkOutput("B.r1AfterR0Drop", seen, 1);

    applyStimulus(1, 0, 5'h02, 8'h00, 0, 1, 0, 5'h09, 8'h00, 1);
    repeat (16) @(negedge clk);
    applyStimulus(1, 0, 5'h02, 8'h00, 0, 1, 0, 5'h09, 8'h00, 0);
    repeat (10) @(negedge clk);

    repeat (1500) begin
      @(negedge clk);
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom),
                    $urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom));
    end

    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 5'h07, 8'h00, 0);
    @(posedge clk);
    #1 applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 checkOutput("B.rdBeforeReset", busB.mem_rd, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("B.rdAfterReset", busB.mem_rd, 0);
    checkOutput("B.busyAfterReset", busB.busy, 0);
    checkOutput("B.gntAfterReset", busB.gnt, 0);
    checkOutput("B.ackAfterReset", busB.r1_ack, 0);
    checkOutput("A.ackAfterReset", busA.r1_ack, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 5'h07, 8'h00, 0);
    measureAck(1'b1, nA, nB, rA, rB);
    checkOutput("A.postResetLatency", nA, 2);
    checkOutput("B.postResetLatency", nB, 4);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
